// File: rtl/hog_stream_arbiter.sv
// Round-robin packet arbiter for HOG block-descriptor streams.
// A source is granted one cycle after it requests. It then owns the merged
// output until PKT_LEN beats have transferred. The arbiter always returns to
// idle for one cycle between packets.
module hog_stream_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRC    = 4,
  parameter int PKT_LEN    = 8,
  parameter int SRC_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         stream,
  output logic                          stream_valid,
  input  logic                          stream_ready,
  output logic [SRC_W-1:0]              src_id,
  output logic                          busy,
  output logic [15:0]                   pkt_count
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           state;
  logic [7:0]       beat_cnt;
  logic [15:0]      pkt_cnt_q;
  logic [SRC_W-1:0] last_grant;

  logic             rr_found;
  logic [SRC_W-1:0] rr_pick;
  logic [SRC_W:0]   rr_cand;
  logic             xfer;
  logic             last_beat;

  // Round-robin pick: scan upward from last_grant+1 with wrap. The candidate
  // carries one extra bit so a single subtraction folds it back into range
  // for any NUM_SRC.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_cand  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      rr_cand = {1'b0, last_grant} + (SRC_W+1)'(k + 1);
      if (rr_cand >= (SRC_W+1)'(NUM_SRC)) begin
        rr_cand = rr_cand - (SRC_W+1)'(NUM_SRC);
      end
      if (!rr_found && src_valid[rr_cand[SRC_W-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand[SRC_W-1:0];
      end
    end
  end

  // Combinational passthrough of the granted source. Everything is zero in idle.
  always_comb begin
    stream       = '0;
    stream_valid = 1'b0;
    src_ready    = '0;
    if (state == S_GRANT) begin
      stream            = src_data[int'(src_id)*DATA_WIDTH +: DATA_WIDTH];
      stream_valid      = src_valid[src_id];
      src_ready[src_id] = stream_ready;
    end
  end

  assign xfer      = stream_valid && stream_ready;
  assign last_beat = (beat_cnt == 8'(PKT_LEN - 1));
  assign busy      = (state == S_GRANT);
  assign pkt_count = pkt_cnt_q;

  // Grant FSM, beat and packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      pkt_cnt_q  <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
      src_id     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && rr_found) begin
            src_id <= rr_pick;
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (xfer) begin
            if (last_beat) begin
              beat_cnt   <= '0;
              pkt_cnt_q  <= pkt_cnt_q + 16'd1;
              last_grant <= src_id;
              state      <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
